// File: rtl/smvm_stream_tx.sv
// -----------------------------------------------------------------------------
// smvm_stream_tx
// Frame transmitter for the SMVM input link. The host fills the vector and
// nonzero buffers and then pulses start. One frame is serialised onto the
// core's in_valid/val_in/ipv_in: the rows word, the cols word, the vector, and
// then the (value,ipv)/(col word) pairs. The pairs are padded up to a multiple
// of K. A forced idle gap follows each frame so the core can recover.
//
// Optional feature: `define SMVM_TX_ROWCHK_EN to count the row_end flags sent
// in value slots. If the count differs from rows, err pulses together with done.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   vec_we/addr/wdata   vector buffer write port (dropped while busy)
//   nz_we/addr/wdata    nonzero buffer write port, {row_end, col[8:0], val[7:0]}
//   start               frame request, sampled in IDLE only
//   rows_i/cols_i/nnz_i frame geometry, sampled with start
//   busy                frame or gap in progress
//   done                1-cycle pulse on the first gap cycle
//   err                 1-cycle pulse: start rejected (or row check failed)
//   tx_valid/val/ipv    registered drive of the core's input link
// -----------------------------------------------------------------------------
module smvm_stream_tx #(
    parameter int unsigned K          = 4,
    parameter int unsigned MAX_COLS   = 511,
    parameter int unsigned MAX_NNZ    = 1024,
    parameter int unsigned NNZ_AW     = 10,
    parameter int unsigned GAP_CYCLES = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              vec_we,
    input  logic [8:0]        vec_addr,
    input  logic [7:0]        vec_wdata,
    input  logic              nz_we,
    input  logic [NNZ_AW-1:0] nz_addr,
    input  logic [17:0]       nz_wdata,
    input  logic              start,
    input  logic [8:0]        rows_i,
    input  logic [8:0]        cols_i,
    input  logic [NNZ_AW:0]   nnz_i,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              tx_valid,
    output logic [7:0]        tx_val,
    output logic              tx_ipv
);

    localparam int unsigned VAW = 9;             // rows/cols/word width
    localparam int unsigned NW  = NNZ_AW + 1;    // nnz count width
    localparam int unsigned CW  = NNZ_AW;        // shared index / gap counter
    localparam int unsigned PW  = $clog2(K) + 1; // pad pair count width

    typedef enum logic [3:0] {
        IDLE, HDR_R, HDR_C, VEC, NZ_VAL, NZ_IDX, PAD_VAL, PAD_IDX, GAP
    } state_e;

    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [VAW-1:0]    rows_q, rows_d;
    logic [VAW-1:0]    cols_q, cols_d;
    logic [NW-1:0]     nnz_q, nnz_d;
    logic [PW-1:0]     pad_q, pad_d;

    logic              tx_valid_q, tx_valid_d;
    logic [7:0]        tx_val_q, tx_val_d;
    logic              tx_ipv_q, tx_ipv_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic              start_ok_c;
    logic [PW-1:0]     rem_c;
    logic [PW-1:0]     pad_c;
    logic [CW-1:0]     last_nz_c;
    logic [17:0]       nz_word_c;
    logic              rowchk_fail_c;

    logic [7:0]        vec_mem [MAX_COLS];
    logic [17:0]       nz_mem  [MAX_NNZ];

    // Buffer writes; host writes are locked out for the whole frame and gap
    always_ff @(posedge clk) begin
        if (vec_we && !busy_q && ({1'b0, vec_addr} < 10'(MAX_COLS))) begin
            vec_mem[vec_addr] <= vec_wdata;
        end
        if (nz_we && !busy_q) begin
            nz_mem[nz_addr] <= nz_wdata;
        end
    end

    // Start validation and pad pair count for the requested nnz
    assign start_ok_c = (cols_i != '0) && ({1'b0, cols_i} <= 10'(MAX_COLS)) &&
                        (nnz_i != '0) && (nnz_i <= NW'(MAX_NNZ));
    assign rem_c      = PW'(nnz_i % NW'(K));
    assign pad_c      = (rem_c == '0) ? '0 : (PW'(K) - rem_c);
    assign last_nz_c  = CW'(nnz_q - NW'(1));

    // State and register file
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            rows_q     <= '0;
            cols_q     <= '0;
            nnz_q      <= '0;
            pad_q      <= '0;
            tx_valid_q <= 1'b0;
            tx_val_q   <= '0;
            tx_ipv_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rows_q     <= rows_d;
            cols_q     <= cols_d;
            nnz_q      <= nnz_d;
            pad_q      <= pad_d;
            tx_valid_q <= tx_valid_d;
            tx_val_q   <= tx_val_d;
            tx_ipv_q   <= tx_ipv_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    // Next state: state_q is the word currently on the link
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rows_d  = rows_q;
        cols_d  = cols_q;
        nnz_d   = nnz_q;
        pad_d   = pad_q;
        case (state_q)
            IDLE: begin
                if (start && start_ok_c) begin
                    state_d = HDR_R;
                    cnt_d   = '0;
                    rows_d  = rows_i;
                    cols_d  = cols_i;
                    nnz_d   = nnz_i;
                    pad_d   = pad_c;
                end
            end
            HDR_R: state_d = HDR_C;
            HDR_C: begin
                state_d = VEC;
                cnt_d   = '0;
            end
            VEC: begin
                if (cnt_q == (CW'(cols_q) - CW'(1))) begin
                    state_d = NZ_VAL;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            NZ_VAL: state_d = NZ_IDX;
            NZ_IDX: begin
                if (cnt_q == last_nz_c) begin
                    state_d = (pad_q != '0) ? PAD_VAL : GAP;
                    cnt_d   = '0;
                end else begin
                    state_d = NZ_VAL;
                    cnt_d   = cnt_q + CW'(1);
                end
            end
            PAD_VAL: state_d = PAD_IDX;
            PAD_IDX: begin
                if (cnt_q == (CW'(pad_q) - CW'(1))) begin
                    state_d = GAP;
                    cnt_d   = '0;
                end else begin
                    state_d = PAD_VAL;
                    cnt_d   = cnt_q + CW'(1);
                end
            end
            GAP: begin
                if (cnt_q == CW'(GAP_CYCLES - 1)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs: computed from the next state so that the registered link
    // carries the word of the state being entered
    always_comb begin
        tx_valid_d = 1'b0;
        tx_val_d   = '0;
        tx_ipv_d   = 1'b0;
        nz_word_c  = nz_mem[cnt_d];
        case (state_d)
            HDR_R: begin
                tx_valid_d           = 1'b1;
                {tx_val_d, tx_ipv_d} = rows_d;
            end
            HDR_C: begin
                tx_valid_d           = 1'b1;
                {tx_val_d, tx_ipv_d} = cols_d;
            end
            VEC: begin
                tx_valid_d = 1'b1;
                tx_val_d   = vec_mem[VAW'(cnt_d)];
            end
            NZ_VAL: begin
                tx_valid_d = 1'b1;
                tx_val_d   = nz_word_c[7:0];
                // Row_end of the last real entry moves onto the last pad pair
                tx_ipv_d   = nz_word_c[17] && !((pad_q != '0) && (cnt_d == last_nz_c));
            end
            NZ_IDX: begin
                tx_valid_d           = 1'b1;
                {tx_val_d, tx_ipv_d} = nz_word_c[16:8];
            end
            PAD_VAL: begin
                tx_valid_d = 1'b1;
                tx_ipv_d   = (cnt_d == (CW'(pad_q) - CW'(1)));
            end
            PAD_IDX: tx_valid_d = 1'b1;
            default: ;
        endcase
        busy_d = (state_d != IDLE);
        done_d = (state_d == GAP) && (state_q != GAP);
        err_d  = ((state_q == IDLE) && start && !start_ok_c) || rowchk_fail_c;
    end

`ifdef SMVM_TX_ROWCHK_EN
    logic [NW-1:0] rowcnt_q, rowcnt_d;

    // Count row_end flags actually sent in value slots
    always_comb begin
        rowcnt_d = rowcnt_q;
        if (state_q == IDLE) begin
            rowcnt_d = '0;
        end else if (((state_d == NZ_VAL) || (state_d == PAD_VAL)) && tx_ipv_d) begin
            rowcnt_d = rowcnt_q + NW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rowcnt_q <= '0;
        end else begin
            rowcnt_q <= rowcnt_d;
        end
    end

    assign rowchk_fail_c = done_d && (rowcnt_q != NW'(rows_q));
`else
    assign rowchk_fail_c = 1'b0;
`endif

    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;
    assign tx_valid = tx_valid_q;
    assign tx_val   = tx_val_q;
    assign tx_ipv   = tx_ipv_q;

endmodule

// File: tb/tb_smvm_stream_tx.sv
// -----------------------------------------------------------------------------
// tb_smvm_stream_tx
// Self-checking bench for smvm_stream_tx. Expected link words are pushed into
// a queue when a frame is requested and popped as the DUT emits them.
// -----------------------------------------------------------------------------
module tb_smvm_stream_tx;

    localparam int K          = 4;
    localparam int MAX_NNZ    = 1024;
    localparam int GAP_CYCLES = 8;

    logic        clk;
    logic        rst_n;
    logic        vec_we;
    logic [8:0]  vec_addr;
    logic [7:0]  vec_wdata;
    logic        nz_we;
    logic [9:0]  nz_addr;
    logic [17:0] nz_wdata;
    logic        start;
    logic [8:0]  rows_i;
    logic [8:0]  cols_i;
    logic [10:0] nnz_i;
    logic        busy;
    logic        done;
    logic        err;
    logic        tx_valid;
    logic [7:0]  tx_val;
    logic        tx_ipv;

    smvm_stream_tx dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .vec_we    (vec_we),
        .vec_addr  (vec_addr),
        .vec_wdata (vec_wdata),
        .nz_we     (nz_we),
        .nz_addr   (nz_addr),
        .nz_wdata  (nz_wdata),
        .start     (start),
        .rows_i    (rows_i),
        .cols_i    (cols_i),
        .nnz_i     (nnz_i),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .tx_valid  (tx_valid),
        .tx_val    (tx_val),
        .tx_ipv    (tx_ipv)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic [8:0] exp_q [$];
    logic [7:0] vec_model [0:510];
    logic [7:0] nz_val_m  [0:1023];
    logic [8:0] nz_col_m  [0:1023];
    logic       nz_re_m   [0:1023];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Link monitor: every valid word must match the next expected word
    always @(negedge clk) begin
        if (rst_n && tx_valid) begin
            chk("tx_pending", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                chk("tx_word", 32'({tx_val, tx_ipv}), 32'(exp_q.pop_front()));
            end
        end
    end

    // Reference frame builder; returns the number of ipv=1 value slots
    task automatic build_expected(input int rows, input int cols, input int nnz,
                                  output int ipv_cnt);
        int         npad;
        logic [7:0] v;
        logic [8:0] c;
        logic       ip;
        npad = ((nnz + K - 1) / K) * K - nnz;
        ipv_cnt = 0;
        exp_q.push_back(9'(rows));
        exp_q.push_back(9'(cols));
        for (int i = 0; i < cols; i++) exp_q.push_back({vec_model[i], 1'b0});
        for (int j = 0; j < nnz + npad; j++) begin
            if (j < nnz) begin
                v  = nz_val_m[j];
                c  = nz_col_m[j];
                ip = nz_re_m[j];
                if (npad > 0 && j == nnz - 1) ip = 1'b0;
            end else begin
                v  = 8'h00;
                c  = 9'h000;
                ip = (j == nnz + npad - 1);
            end
            ipv_cnt += int'(ip);
            exp_q.push_back({v, ip});
            exp_q.push_back(c);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_vec(input int a, input logic [7:0] d);
        vec_we = 1'b1; vec_addr = 9'(a); vec_wdata = d;
        tick();
        vec_we = 1'b0;
        vec_model[a] = d;
    endtask

    task automatic write_nz(input int a, input logic re, input logic [8:0] c,
                            input logic [7:0] v);
        nz_we = 1'b1; nz_addr = 10'(a); nz_wdata = {re, c, v};
        tick();
        nz_we = 1'b0;
        nz_re_m[a] = re; nz_col_m[a] = c; nz_val_m[a] = v;
    endtask

    // Full accepted frame; inject=1 pulses start and buffer writes mid-frame
    task automatic run_frame(input int rows, input int cols, input int nnz, input bit inject);
        int cyc;
        int flen;
        int ipc;
        bit exp_err;
        build_expected(rows, cols, nnz, ipc);
`ifdef SMVM_TX_ROWCHK_EN
        exp_err = (ipc != rows);
`else
        exp_err = 1'b0;
`endif
        flen = 2 + cols + 2 * ((nnz + K - 1) / K) * K;
        rows_i = 9'(rows); cols_i = 9'(cols); nnz_i = 11'(nnz);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("busy_after_start", 32'(busy), 32'd1);
        chk("hdr_rows", 32'({tx_val, tx_ipv}), 32'(rows));
        cyc = 1;
        while (!done && cyc < 3000) begin
            if (inject && cyc == 5) begin
                start = 1'b1;
                vec_we = 1'b1; vec_addr = 9'd0; vec_wdata = 8'hFF;
                nz_we = 1'b1; nz_addr = 10'd0; nz_wdata = 18'h3FFFF;
            end
            tick();
            start = 1'b0; vec_we = 1'b0; nz_we = 1'b0;
            cyc++;
        end
        chk("done_latency", 32'(cyc), 32'(flen + 1));
        chk("done_txvalid", 32'(tx_valid), 32'd0);
        chk("err_at_done", 32'(err), 32'(exp_err));
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        repeat (GAP_CYCLES - 1) tick();
        chk("busy_last_gap", 32'(busy), 32'd1);
        tick();
        chk("busy_after_gap", 32'(busy), 32'd0);
    endtask

    // Rejected start: err next cycle, nothing sent, busy stays low
    task automatic reject(input int rows, input int cols, input int nnz);
        rows_i = 9'(rows); cols_i = 9'(cols); nnz_i = 11'(nnz);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("rej_err", 32'(err), 32'd1);
        chk("rej_busy", 32'(busy), 32'd0);
        chk("rej_txvalid", 32'(tx_valid), 32'd0);
        tick();
        chk("rej_err_clear", 32'(err), 32'd0);
        chk("rej_busy2", 32'(busy), 32'd0);
        chk("rej_txvalid2", 32'(tx_valid), 32'd0);
    endtask

    initial begin
        int dummy;
        rst_n = 1'b0; vec_we = 1'b0; vec_addr = '0; vec_wdata = '0;
        nz_we = 1'b0; nz_addr = '0; nz_wdata = '0; start = 1'b0;
        rows_i = '0; cols_i = '0; nnz_i = '0;
        repeat (2) tick();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_txvalid", 32'(tx_valid), 32'd0);
        chk("rst_txword", 32'({tx_val, tx_ipv}), 32'd0);
        rst_n = 1'b1;
        tick();

        // Basic frame: rows=2, cols=3, 4 nonzeros, row_end on #2 and #4
        write_vec(0, 8'd5); write_vec(1, 8'd6); write_vec(2, 8'd7);
        write_nz(0, 1'b0, 9'd0, 8'h11);
        write_nz(1, 1'b1, 9'd2, 8'h22);
        write_nz(2, 1'b0, 9'd1, 8'h33);
        write_nz(3, 1'b1, 9'h105, 8'h44);
        run_frame(2, 3, 4, 1'b0);

        // Start and buffer writes during a frame are ignored
        run_frame(2, 3, 4, 1'b1);
        run_frame(2, 3, 4, 1'b0);

        // nnz=5 padded to 8 pairs, row_end relocated to the last pad
        write_nz(4, 1'b1, 9'd2, 8'h55);
        run_frame(2, 3, 5, 1'b0);

        // Rejected starts
        reject(2, 0, 4);
        reject(2, 3, MAX_NNZ + 1);
        reject(2, 3, 0);

        // Reset in the middle of the vector phase, then a clean frame
        build_expected(2, 3, 4, dummy);
        rows_i = 9'd2; cols_i = 9'd3; nnz_i = 11'd4;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_txvalid", 32'(tx_valid), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        exp_q.delete();
        tick();
        rst_n = 1'b1;
        tick();
        run_frame(2, 3, 4, 1'b0);

        // Row count mismatch: rows=3 but only two row_end flags
        run_frame(3, 3, 4, 1'b0);

        // Randomised geometry, rows taken from the frame itself
        for (int i = 0; i < 9; i++) write_vec(i, 8'($urandom_range(0, 255)));
        for (int j = 0; j < 7; j++)
            write_nz(j, 1'($urandom_range(0, 1)), 9'($urandom_range(0, 8)),
                     8'($urandom_range(0, 255)));
        nz_re_m[6] = 1'b1;
        write_nz(6, 1'b1, nz_col_m[6], nz_val_m[6]);
        begin
            int cnt;
            cnt = 0;
            for (int j = 0; j < 6; j++) cnt += int'(nz_re_m[j]);
            run_frame(cnt + 1, 9, 7, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
